// File: rtl/i2c_codec_target.sv
// I2C target modelling the audio codec control port: takes 3-byte writes
// (address 0x34, then a 16-bit word), decodes {reg[6:0], data[8:0]} and
// commits the data into a small register file.
//
// Ports:
//   clk, reset       system clock (>= 8x SCL), async active-high reset
//   i2c_sclk         SCL from the initiator
//   i2c_sdat         open-drain SDA, driven only 0 or z
//   wr_valid/wr_err  one-cycle commit pulse / out-of-range flag
//   wr_addr/wr_data  address and data of the last commit
//   rd_addr/rd_data  combinational register readback
//   codec_active     bit 0 of register ACTIVE_REG
//   status           committed-write count, modulo 16
module i2c_codec_target #(
  parameter logic [6:0] DEV_ADDR   = 7'h1A,
  parameter int         NUM_REGS   = 16,
  parameter logic [6:0] RESET_REG  = 7'h0F,
  parameter logic [6:0] ACTIVE_REG = 7'h09
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i2c_sclk,
  inout  wire        i2c_sdat,
  output logic       wr_valid,
  output logic [6:0] wr_addr,
  output logic [8:0] wr_data,
  output logic       wr_err,
  input  logic [3:0] rd_addr,
  output logic [8:0] rd_data,
  output logic       codec_active,
  output logic [3:0] status
);

  localparam int IW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [7:0] NREG8 = 8'(NUM_REGS);
  localparam logic [IW-1:0] ACT_IDX = IW'(ACTIVE_REG);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_ADDR_ACK,
    S_BYTE_HI,
    S_ACK_HI,
    S_BYTE_LO,
    S_ACK_LO,
    S_WAIT_STOP
  } state_e;

  // synchronizers and edge detection
  logic scl_s1_q, scl_s2_q, scl_p_q;
  logic sda_s1_q, sda_s2_q, sda_p_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scl_s1_q <= 1'b1;
      scl_s2_q <= 1'b1;
      scl_p_q  <= 1'b1;
      sda_s1_q <= 1'b1;
      sda_s2_q <= 1'b1;
      sda_p_q  <= 1'b1;
    end else begin
      scl_s1_q <= i2c_sclk;
      scl_s2_q <= scl_s1_q;
      scl_p_q  <= scl_s2_q;
      sda_s1_q <= i2c_sdat;
      sda_s2_q <= sda_s1_q;
      sda_p_q  <= sda_s2_q;
    end
  end

  logic start_ev, stop_ev, scl_rise, scl_fall;

  assign start_ev = scl_s2_q & sda_p_q & ~sda_s2_q;
  assign stop_ev  = scl_s2_q & ~sda_p_q & sda_s2_q;
  assign scl_rise = ~scl_p_q & scl_s2_q;
  assign scl_fall = scl_p_q & ~scl_s2_q;

  state_e state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] hi_q, hi_d;
  logic byte_done;

  // a byte is complete at the SCL fall after its 8th rising edge
  assign byte_done = scl_fall & (cnt_q == 4'd8);

  // FSM: state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    if (stop_ev) begin
      state_d = S_IDLE;
    end else if (start_ev) begin
      state_d = S_ADDR;
    end else begin
      unique case (state_q)
        S_IDLE:      state_d = S_IDLE;
        S_ADDR:
          if (byte_done)
            state_d = (shift_q == {DEV_ADDR, 1'b0}) ?
                      S_ADDR_ACK : S_WAIT_STOP;
        S_ADDR_ACK:  if (scl_fall) state_d = S_BYTE_HI;
        S_BYTE_HI:   if (byte_done) state_d = S_ACK_HI;
        S_ACK_HI:    if (scl_fall) state_d = S_BYTE_LO;
        S_BYTE_LO:   if (byte_done) state_d = S_ACK_LO;
        S_ACK_LO:    if (scl_fall) state_d = S_WAIT_STOP;
        S_WAIT_STOP: state_d = S_WAIT_STOP;
        default:     state_d = S_IDLE;
      endcase
    end
  end

  // FSM: outputs
  logic sda_drive, rx_bits, commit;

  always_comb begin
    sda_drive = 1'b0;
    rx_bits   = 1'b0;
    commit    = 1'b0;
    unique case (state_q)
      S_ADDR, S_BYTE_HI, S_BYTE_LO: rx_bits = 1'b1;
      S_ADDR_ACK, S_ACK_HI:         sda_drive = 1'b1;
      S_ACK_LO: begin
        sda_drive = 1'b1;
        commit    = scl_fall & ~start_ev & ~stop_ev;
      end
      default: ;
    endcase
  end

  assign i2c_sdat = sda_drive ? 1'b0 : 1'bz;

  // bit counter and byte capture; WAIT_STOP shifts nothing so extra
  // bytes are simply ignored (and NACKed by not driving)
  always_comb begin
    cnt_d   = cnt_q;
    shift_d = shift_q;
    hi_d    = hi_q;
    if (start_ev || stop_ev) begin
      cnt_d = 4'd0;
    end else if (rx_bits && scl_rise && cnt_q != 4'd8) begin
      shift_d = {shift_q[6:0], sda_s2_q};
      cnt_d   = cnt_q + 4'd1;
    end else if (byte_done) begin
      cnt_d = 4'd0;
      if (state_q == S_BYTE_HI) hi_d = shift_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q   <= 4'd0;
      shift_q <= 8'd0;
      hi_q    <= 8'd0;
    end else begin
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      hi_q    <= hi_d;
    end
  end

  // commit stage
  logic       wr_valid_q, wr_valid_d;
  logic       wr_err_q, wr_err_d;
  logic [6:0] wr_addr_q, wr_addr_d;
  logic [8:0] wr_data_q, wr_data_d;
  logic [3:0] status_q, status_d;
  logic [6:0] c_addr;
  logic [8:0] c_data;
  logic       c_clear, c_in_range;

  assign c_addr     = hi_q[7:1];
  assign c_data     = {hi_q[0], shift_q};
  assign c_clear    = (c_addr == RESET_REG) && (c_data == 9'd0);
  assign c_in_range = {1'b0, c_addr} < NREG8;

  always_comb begin
    wr_valid_d = commit;
    wr_err_d   = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    status_d   = status_q;
    if (commit) begin
      wr_addr_d = c_addr;
      wr_data_d = c_data;
      wr_err_d  = ~c_clear & ~c_in_range;
      status_d  = status_q + 4'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_valid_q <= 1'b0;
      wr_err_q   <= 1'b0;
      wr_addr_q  <= 7'd0;
      wr_data_q  <= 9'd0;
      status_q   <= 4'd0;
    end else begin
      wr_valid_q <= wr_valid_d;
      wr_err_q   <= wr_err_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      status_q   <= status_d;
    end
  end

  // register file is updated from the committed word, so the new value
  // shows up one cycle after the wr_valid pulse
  logic [8:0] regs_q [NUM_REGS];
  logic       w_clear, w_in_range, rd_ok;

  assign w_clear    = (wr_addr_q == RESET_REG) && (wr_data_q == 9'd0);
  assign w_in_range = {1'b0, wr_addr_q} < NREG8;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= 9'd0;
    end else if (wr_valid_q) begin
      if (w_clear) begin
        for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= 9'd0;
      end else if (w_in_range) begin
        regs_q[IW'(wr_addr_q)] <= wr_data_q;
      end
    end
  end

  assign rd_ok        = {4'd0, rd_addr} < NREG8;
  assign rd_data      = rd_ok ? regs_q[IW'(rd_addr)] : 9'd0;
  assign codec_active = regs_q[ACT_IDX][0];

  assign wr_valid = wr_valid_q;
  assign wr_err   = wr_err_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;
  assign status   = status_q;

endmodule

// File: tb/tb_i2c_codec_target.sv
// Bench for i2c_codec_target: bit-banged I2C initiator, directed table,
// hand-written corner sequences and randomized transactions vs a model.
module tb_i2c_codec_target;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       scl = 1'b1;
  logic       m_low = 1'b0;
  wire        i2c_sdat;
  logic       wr_valid, wr_err, codec_active;
  logic [6:0] wr_addr;
  logic [8:0] wr_data, rd_data;
  logic [3:0] rd_addr = 4'd0;
  logic [3:0] status;

  pullup (i2c_sdat);
  assign i2c_sdat = m_low ? 1'b0 : 1'bz;

  always #5 clk = ~clk;

  i2c_codec_target dut (
    .clk(clk), .reset(reset),
    .i2c_sclk(scl), .i2c_sdat(i2c_sdat),
    .wr_valid(wr_valid), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_err(wr_err),
    .rd_addr(rd_addr), .rd_data(rd_data),
    .codec_active(codec_active), .status(status)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [16:0] mon_q[$];
  logic [16:0] exp_q[$];
  logic [8:0]  mdl [16];
  logic [3:0]  mstat = 4'd0;

  always @(negedge clk)
    if (!reset && wr_valid)
      mon_q.push_back({wr_err, wr_addr, wr_data});

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // reference model: word -> {reg, data}, applied to an array
  task automatic model_write(input logic [15:0] w);
    logic [6:0] a;
    logic [8:0] d;
    a = w[15:9];
    d = w[8:0];
    exp_q.push_back({a >= 7'd16, a, d});
    mstat = mstat + 4'd1;
    if (a == 7'h0F && d == 9'd0)
      for (int i = 0; i < 16; i++) mdl[i] = 9'd0;
    else if (a < 7'd16)
      mdl[a[3:0]] = d;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) mdl[i] = 9'd0;
    mstat = 4'd0;
    exp_q.delete();
  endtask

  task automatic check_commits(input string nm);
    int n;
    chk({nm, "_ncommit"}, mon_q.size(), exp_q.size());
    n = (mon_q.size() < exp_q.size()) ? mon_q.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      chk({nm, "_commit"}, mon_q[i], exp_q[i]);
    mon_q.delete();
    exp_q.delete();
  endtask

  task automatic check_regs(input string nm);
    for (int i = 0; i < 16; i++) begin
      rd_addr = 4'(i);
      #1;
      chk({nm, "_rd"}, rd_data, mdl[i]);
    end
    chk({nm, "_active"}, codec_active, mdl[9][0]);
    chk({nm, "_status"}, status, mstat);
  endtask

  // bus primitives; one quarter SCL period = 5 clocks
  task automatic qp();
    repeat (5) @(posedge clk);
  endtask

  task automatic bstart();
    m_low = 1'b0; qp();
    scl = 1'b1; qp();
    m_low = 1'b1; qp();
    scl = 1'b0; qp();
  endtask

  task automatic bstop();
    m_low = 1'b1; qp();
    scl = 1'b1; qp();
    m_low = 1'b0; qp(); qp();
  endtask

  task automatic bbits(input logic [7:0] b, input int nb);
    for (int i = 7; i > 7 - nb; i--) begin
      m_low = ~b[i]; qp();
      scl = 1'b1; qp(); qp();
      scl = 1'b0; qp();
    end
  endtask

  task automatic bbyte(input logic [7:0] b, output logic ack);
    bbits(b, 8);
    m_low = 1'b0; qp();
    scl = 1'b1; qp();
    #1 ack = (i2c_sdat == 1'b0);
    qp();
    scl = 1'b0; qp();
  endtask

  task automatic full_write(input logic [15:0] w, output logic [2:0] acks);
    bstart();
    bbyte(8'h34, acks[2]);
    bbyte(w[15:8], acks[1]);
    bbyte(w[7:0], acks[0]);
    bstop();
  endtask

  typedef struct {
    logic [15:0] word;
    logic [16:0] exp_commit;
    logic [3:0]  rd;
    logic [8:0]  exp_rd;
    logic        exp_act;
  } vec_t;

  vec_t vecs[11];

  initial begin
    logic [2:0] acks;
    logic       a0, a1, a2, a3;
    logic [15:0] w;
    logic [6:0] ra;
    logic [8:0] rdv;
    int kind;

    vecs[0]  = '{16'h0C10, {1'b0, 7'h06, 9'h010}, 4'd6, 9'h010, 1'b0};
    vecs[1]  = '{16'h0017, {1'b0, 7'h00, 9'h017}, 4'd0, 9'h017, 1'b0};
    vecs[2]  = '{16'h0217, {1'b0, 7'h01, 9'h017}, 4'd1, 9'h017, 1'b0};
    vecs[3]  = '{16'h0479, {1'b0, 7'h02, 9'h079}, 4'd2, 9'h079, 1'b0};
    vecs[4]  = '{16'h0679, {1'b0, 7'h03, 9'h079}, 4'd3, 9'h079, 1'b0};
    vecs[5]  = '{16'h08D4, {1'b0, 7'h04, 9'h0D4}, 4'd4, 9'h0D4, 1'b0};
    vecs[6]  = '{16'h0A04, {1'b0, 7'h05, 9'h004}, 4'd5, 9'h004, 1'b0};
    vecs[7]  = '{16'h0E01, {1'b0, 7'h07, 9'h001}, 4'd7, 9'h001, 1'b0};
    vecs[8]  = '{16'h1020, {1'b0, 7'h08, 9'h020}, 4'd8, 9'h020, 1'b0};
    vecs[9]  = '{16'h0C00, {1'b0, 7'h06, 9'h000}, 4'd6, 9'h000, 1'b0};
    vecs[10] = '{16'h1201, {1'b0, 7'h09, 9'h001}, 4'd9, 9'h001, 1'b1};

    model_reset();
    repeat (4) @(posedge clk);
    #1;
    chk("rst_valid", wr_valid, 1'b0);
    chk("rst_status", status, 4'd0);
    chk("rst_active", codec_active, 1'b0);
    chk("rst_sda", i2c_sdat, 1'b1);
    reset = 1'b0;
    qp();
    check_regs("rst");

    // configuration sequence
    for (int i = 0; i < 11; i++) begin
      full_write(vecs[i].word, acks);
      model_write(vecs[i].word);
      exp_q.delete();
      chk("seq_acks", acks, 3'b111);
      chk("seq_ncommit", mon_q.size(), 1);
      if (mon_q.size() > 0)
        chk("seq_commit", mon_q[0], vecs[i].exp_commit);
      mon_q.delete();
      rd_addr = vecs[i].rd;
      #1;
      chk("seq_rd", rd_data, vecs[i].exp_rd);
      chk("seq_active", codec_active, vecs[i].exp_act);
    end
    chk("seq_status", status, 4'hB);
    rd_addr = 4'd6; #1 chk("seq_reg6", rd_data, 9'h000);
    rd_addr = 4'd2; #1 chk("seq_reg2", rd_data, 9'h079);
    rd_addr = 4'd8; #1 chk("seq_reg8", rd_data, 9'h020);

    // wrong address and read bit
    bstart(); bbyte(8'h36, a0); bbyte(8'h0C, a1); bbyte(8'h55, a2); bstop();
    chk("nack_36", a0, 1'b0);
    chk("nack_36_data", a1, 1'b0);
    bstart(); bbyte(8'h35, a0); bstop();
    chk("nack_35", a0, 1'b0);
    check_commits("nack");
    check_regs("nack");

    // stop after hi byte, then a normal write
    bstart(); bbyte(8'h34, a0); bbyte(8'h04, a1); bstop();
    chk("part_acks", {a0, a1}, 2'b11);
    check_commits("part");
    chk("part_status", status, mstat);
    full_write(16'h0A05, acks);
    model_write(16'h0A05);
    chk("part_next_acks", acks, 3'b111);
    check_commits("part_next");
    check_regs("part_next");

    // out of range, then clear-all
    full_write(16'h2201, acks);
    model_write(16'h2201);
    chk("err_acks", acks, 3'b111);
    chk("err_flag", mon_q.size() > 0 ? mon_q[0][16] : 1'b0, 1'b1);
    check_commits("err");
    check_regs("err");
    full_write(16'h1E00, acks);
    model_write(16'h1E00);
    check_commits("clr");
    check_regs("clr");
    chk("clr_active", codec_active, 1'b0);

    // repeated start after hi byte
    bstart(); bbyte(8'h34, a0); bbyte(8'h0C, a1);
    full_write(16'h0A04, acks);
    model_write(16'h0A04);
    chk("sr_acks", acks, 3'b111);
    check_commits("sr");
    check_regs("sr");

    // fourth data byte
    bstart(); bbyte(8'h34, a0); bbyte(8'h0C, a1); bbyte(8'h22, a2);
    bbyte(8'h55, a3); bstop();
    model_write(16'h0C22);
    chk("x4_acks", {a0, a1, a2}, 3'b111);
    chk("x4_nack", a3, 1'b0);
    check_commits("x4");
    check_regs("x4");

    // reset in the middle of the lo byte
    bstart(); bbyte(8'h34, a0); bbyte(8'h12, a1);
    bbits(8'h0F, 4);
    m_low = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    chk("rrst_sda", i2c_sdat, 1'b1);
    chk("rrst_status", status, 4'd0);
    chk("rrst_valid", wr_valid, 1'b0);
    model_reset();
    mon_q.delete();
    repeat (3) @(posedge clk);
    reset = 1'b0;
    bbits(8'hF0, 4);
    m_low = 1'b0; qp();
    scl = 1'b1; qp();
    check_commits("rrst");
    full_write(16'h1201, acks);
    model_write(16'h1201);
    chk("rrst_acks", acks, 3'b111);
    check_commits("rrst_next");
    check_regs("rrst_next");

    // randomized transactions
    for (int t = 0; t < 30; t++) begin
      kind = $urandom_range(0, 4);
      ra = 7'($urandom_range(0, 19));
      rdv = 9'($urandom);
      w = ($urandom_range(0, 7) == 0) ? 16'h1E00 : {ra, rdv};
      unique case (kind)
        0: begin
          full_write(w, acks);
          model_write(w);
          chk("rnd_full_acks", acks, 3'b111);
        end
        1: begin
          w[15:8] = 8'($urandom);
          if (w[15:8] == 8'h34) w[15:8] = 8'h35;
          bstart(); bbyte(w[15:8], a0); bstop();
          chk("rnd_badaddr", a0, 1'b0);
        end
        2: begin
          bstart(); bbyte(8'h34, a0); bbyte(w[15:8], a1); bstop();
          chk("rnd_part_acks", {a0, a1}, 2'b11);
        end
        3: begin
          bstart(); bbyte(8'h34, a0); bbyte(w[15:8], a1);
          bbyte(w[7:0], a2); bbyte(8'($urandom), a3); bstop();
          model_write(w);
          chk("rnd_x4_acks", {a0, a1, a2, a3}, 4'b1110);
        end
        default: begin
          bstart(); bbyte(8'h34, a0); bbyte(8'($urandom), a1);
          full_write(w, acks);
          model_write(w);
          chk("rnd_sr_acks", acks, 3'b111);
        end
      endcase
      check_commits("rnd");
      chk("rnd_status", status, mstat);
      if (t % 6 == 5) check_regs("rnd");
    end
    check_regs("final");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/i2c_codec_target.md
Name: i2c_codec_target

Overview:
I2C target (responder) that models the audio codec's control port. It accepts the 3-byte write transactions issued by the codec configuration sequencer: device address, then a 16-bit control word. It decodes each word into a 7-bit register address and 9-bit data, and commits the data to an internal register file. Used in simulation and on-chip loopback to check codec configuration without the physical part.

Parameters:
DEV_ADDR, 7'h1A, 7-bit target address; the write address byte is 8'h34.
NUM_REGS, 16, number of implemented registers, indices 0..NUM_REGS-1.
RESET_REG, 7'h0F, register index whose write clears the whole file.
ACTIVE_REG, 7'h09, register index whose bit 0 drives codec_active.

Ports:
clk  in  1  system clock; must be at least 8x the SCL frequency.
reset  in  1  asynchronous, active-high reset.
i2c_sclk  in  1  I2C clock from the initiator.
i2c_sdat  inout  1  open-drain I2C data; driven only as 1'b0 or 1'bz.
wr_valid  out  1  one-cycle pulse when a write commits.
wr_addr  out  7  register address of the last commit.
wr_data  out  9  data of the last commit.
wr_err  out  1  one-cycle pulse, coincident with wr_valid, when wr_addr >= NUM_REGS.
rd_addr  in  4  combinational readback index.
rd_data  out  9  register file contents at rd_addr.
codec_active  out  1  bit 0 of register ACTIVE_REG.
status  out  4  count of committed writes, modulo 16.

Behaviour:
- Reset (asynchronous):
  - All registers 0; wr_valid, wr_err, wr_addr, wr_data, status = 0; codec_active = 0; i2c_sdat released (z); FSM to IDLE.
  - Reset asserted mid-transaction aborts the transaction with no commit. After reset deasserts, the target ignores the bus until the next START.
- Input sampling:
  - SCL and SDA each pass through a 2-flop synchronizer, plus a previous-value flop for edge detection.
  - START = synced SDA 1->0 while synced SCL = 1. STOP = synced SDA 0->1 while synced SCL = 1.
  - START and STOP take priority over data handling in the same cycle.
- Bit timing:
  - Data bits are sampled on SCL rising edges, MSB first.
  - ACK: pull SDA low starting at the SCL falling edge after bit 8, release at the following SCL falling edge (after the 9th clock).
  - NACK: leave SDA released through the 9th clock.
- FSM states: IDLE, ADDR, ADDR_ACK, BYTE_HI, ACK_HI, BYTE_LO, ACK_LO, WAIT_STOP.
  - IDLE: on START -> ADDR.
  - ADDR: after 8 bits, if byte == {DEV_ADDR, 1'b0} -> ADDR_ACK (ACK). Otherwise (wrong address or R/W = 1) -> WAIT_STOP (NACK). Reads are not supported.
  - ADDR_ACK -> BYTE_HI after the 9th SCL falling edge.
  - BYTE_HI: after 8 bits -> ACK_HI (ACK), holding hi byte.
  - ACK_HI -> BYTE_LO.
  - BYTE_LO: after 8 bits -> ACK_LO (ACK).
  - ACK_LO: at the 9th SCL falling edge, commit, then -> WAIT_STOP.
  - WAIT_STOP: any further bytes are NACKed and ignored.
  - Any state: STOP -> IDLE; repeated START -> ADDR. A partial (uncommitted) word is discarded in both cases.
- Commit (single clk cycle):
  - wr_addr = hi[7:1]; wr_data = {hi[0], lo}; wr_valid = 1; status increments, wrapping 15 -> 0.
  - If wr_addr == RESET_REG and wr_data == 0: clear all registers.
  - Else if wr_addr < NUM_REGS: reg[wr_addr] <= wr_data.
  - Else: no update, wr_err = 1.
  - The register write is visible on rd_data and codec_active the cycle after wr_valid.
- Address and data bytes are ACKed regardless of register range; range errors are reported only on wr_err.
- SDA is never driven high. i2c_sdat = (drive_low) ? 1'b0 : 1'bz.

Test Plan:
- Full sequence of 11 writes (0x0C10, 0x0017, 0x0217, 0x0479, 0x0679, 0x08D4, 0x0A04, 0x0E01, 0x1020, 0x0C00, 0x1201), each framed START/8'h34/hi/lo/STOP -> 3 ACKs per write; 11 wr_valid pulses; status = 4'hB. Readback: reg6 = 0x000, reg2 = 0x079, reg8 = 0x020. codec_active = 1 after 0x1201.
- Address byte 8'h36, then 8'h35 -> NACK on the 9th clock, no wr_valid, registers unchanged.
- START/8'h34/8'h04/STOP (stop after hi byte) -> no commit, status unchanged; the next full write commits normally.
- Write 0x2201 (addr 0x11) -> ACKs, wr_valid with wr_err = 1, no register change. Then 0x1E00 -> all registers 0, codec_active = 0.
- Repeated START after the hi byte, then a full 0x0A04 write -> only reg5 = 0x004 committed. A 4th data byte in one transaction is NACKed with no second commit.
- reset pulsed during BYTE_LO -> SDA released within 1 cycle, no commit; a subsequent transaction starting with START is ACKed.
